// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: rasterizer pixel writes -> address stage -> FIFO -> memory req/ack port.
// Optional full-framebuffer clear sweep is compiled in when FB_CLEAR_EN is defined.
module fb_pixel_writer #(
  parameter int FIFO_DEPTH = 16,
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              pix_we,
  input  logic [9:0]        pix_x,
  input  logic [9:0]        pix_y,
  input  logic [3:0]        pix_data,
  output logic              pix_full,
  output logic              overflow,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic              clear_start,
  input  logic [3:0]        clear_color,
  output logic              clear_busy,
  output logic              idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + 4;
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]    AFULL_CNT = (PTR_W+1)'(FIFO_DEPTH - 2);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

  state_t state, state_next;

  logic              in_bounds;
  logic              s_valid;
  logic [ADDR_W-1:0] s_addr;
  logic [3:0]        s_data;
  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr, count;
  logic              fifo_empty, fifo_full;
  logic              push, pop, stage_hold, out_free;
  logic              clear_load, clear_step, clear_done;
  logic [3:0]        clear_color_q;

  assign in_bounds  = (32'(pix_x) < FB_WIDTH) && (32'(pix_y) < FB_HEIGHT);
  assign count      = wr_ptr - rd_ptr;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pix_full   = (count >= AFULL_CNT);
  assign out_free   = !mem_req || mem_ack;
  assign push       = s_valid && (!fifo_full || pop);
  assign stage_hold = s_valid && !push;
  assign idle       = fifo_empty && !s_valid && !mem_req && !clear_busy;

  // Address stage: registered multiply-add; holds its pixel while the FIFO cannot accept it
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s_valid <= 1'b0;
      s_addr  <= '0;
      s_data  <= '0;
    end else if (!stage_hold) begin
      s_valid <= pix_we && in_bounds;
      s_addr  <= ADDR_W'(pix_y) * ADDR_W'(FB_WIDTH) + ADDR_W'(pix_x);
      s_data  <= pix_data;
    end
  end

  // Sticky drop flag: an in-bounds pixel arrived while the address stage was held
  always_ff @(posedge clk or posedge areset) begin
    if (areset)
      overflow <= 1'b0;
    else if (stage_hold && pix_we && in_bounds)
      overflow <= 1'b1;
  end

  // FIFO storage (no reset needed, validity tracked by the pointers)
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr[PTR_W-1:0]] <= {s_addr, s_data};
  end

  // FIFO pointers with an extra wrap bit so full and empty are distinguishable
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

`ifdef FB_CLEAR_EN
  // Clear request latch: busy covers both pending and in-progress sweeps
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      clear_busy    <= 1'b0;
      clear_color_q <= '0;
    end else if (clear_start && !clear_busy) begin
      clear_busy    <= 1'b1;
      clear_color_q <= clear_color;
    end else if (clear_done) begin
      clear_busy    <= 1'b0;
    end
  end
`else
  logic unused_clear;
  assign clear_busy    = 1'b0;
  assign clear_color_q = '0;
  assign unused_clear  = ^{clear_start, clear_color};
`endif

  // FSM state register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    clear_load = 1'b0;
    clear_step = 1'b0;
    clear_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop        = out_free;
          state_next = S_WRITE;
        end
`ifdef FB_CLEAR_EN
        else if (clear_busy && !s_valid && !mem_req) begin
          clear_load = 1'b1;
          state_next = S_CLEAR;
        end
`endif
      end
      S_WRITE: begin
        if (!fifo_empty)   pop        = out_free;
        else if (out_free) state_next = S_IDLE;
      end
`ifdef FB_CLEAR_EN
      S_CLEAR: begin
        if (mem_ack) begin
          if (mem_addr == LAST_ADDR) begin
            clear_done = 1'b1;
            state_next = S_IDLE;
          end else begin
            clear_step = 1'b1;
          end
        end
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // Output register: reload on the ack cycle so transfers run back-to-back
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (pop) begin
      mem_req                <= 1'b1;
      {mem_addr, mem_wdata}  <= fifo_mem[rd_ptr[PTR_W-1:0]];
    end else if (clear_load) begin
      mem_req   <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= clear_color_q;
    end else if (clear_step) begin
      mem_addr  <= mem_addr + 1'b1;
    end else if (mem_ack) begin
      mem_req   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer with a write scoreboard; clear tests need FB_CLEAR_EN.
module tb_fb_pixel_writer;

  localparam int FB_W   = 640;
  localparam int FB_H   = 3;
  localparam int ADDR_W = 19;
  localparam int LAST   = FB_W * FB_H - 1;

  logic              clk = 1'b0;
  logic              areset;
  logic              pix_we;
  logic [9:0]        pix_x, pix_y;
  logic [3:0]        pix_data;
  logic              pix_full, overflow, mem_req, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_wdata;
  logic              clear_start;
  logic [3:0]        clear_color;
  logic              clear_busy, idle;

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+3:0] sb [$];

  fb_pixel_writer #(.FIFO_DEPTH(16), .FB_WIDTH(FB_W), .FB_HEIGHT(FB_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .areset(areset), .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data), .pix_full(pix_full), .overflow(overflow), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input int x, input int y, input logic [3:0] d);
    pix_we   = 1'b1;
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    pix_data = d;
  endtask

  task automatic push_exp(input int x, input int y, input logic [3:0] d);
    sb.push_back({ADDR_W'(y * FB_W + x), d});
  endtask

  task automatic push_clear(input logic [3:0] c);
    for (int a = 0; a <= LAST; a++) sb.push_back({ADDR_W'(a), c});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (idle && sb.size() == 0) break;
    end
    chk({tag, "_idle"}, 32'(idle), 32'd1);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(mem_req),    32'd0);
    chk({tag, "_addr"},  32'(mem_addr),   32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata),  32'd0);
    chk({tag, "_full"},  32'(pix_full),   32'd0);
    chk({tag, "_ovf"},   32'(overflow),   32'd0);
    chk({tag, "_busy"},  32'(clear_busy), 32'd0);
    chk({tag, "_idle"},  32'(idle),       32'd1);
  endtask

  // Scoreboard monitor: each accepted write must match the oldest expectation;
  // a stalled request must hold its address and data.
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [3:0]        prev_data;
  always @(negedge clk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("stall_stable", 32'({mem_req, mem_addr, mem_wdata}), 32'({1'b1, prev_addr, prev_data}));
      if (mem_req && mem_ack) begin
        chk("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          logic [ADDR_W+3:0] e;
          e = sb.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(e[ADDR_W+3:4]));
          chk("wr_data", 32'(mem_wdata), 32'(e[3:0]));
        end
      end
      prev_stall = mem_req && !mem_ack;
      prev_addr  = mem_addr;
      prev_data  = mem_wdata;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] bx [4];
    logic [9:0] by [4];
    bit done;
    areset = 1'b1; pix_we = 1'b0; pix_x = '0; pix_y = '0; pix_data = '0;
    mem_ack = 1'b0; clear_start = 1'b0; clear_color = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    tick(); areset = 1'b0;

    // 1: single pixel, latency 3, address y*640+x
    mem_ack = 1'b1;
    tick(); drive_pix(3, 2, 4'hF); push_exp(3, 2, 4'hF);
    @(negedge clk); chk("t1_req_c0", 32'(mem_req), 32'd0);
    tick(); pix_we = 1'b0;
    @(negedge clk); chk("t1_req_c1", 32'(mem_req), 32'd0);
    tick();
    @(negedge clk); chk("t1_req_c2", 32'(mem_req), 32'd0);
    tick();
    @(negedge clk);
    chk("t1_req_c3", 32'(mem_req), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'd1283);
    chk("t1_data", 32'(mem_wdata), 32'hF);
    tick();
    @(negedge clk);
    chk("t1_req_c4", 32'(mem_req), 32'd0);
    chk("t1_idle", 32'(idle), 32'd1);

    // 2: memory stalled, 20 back-to-back pixels; 18 fit, 19 and 20 drop
    mem_ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c < 20) begin
        drive_pix(c + 1, 1, 4'(c + 1));
        if (c + 1 <= 18) push_exp(c + 1, 1, 4'(c + 1));
      end else begin
        pix_we = 1'b0;
      end
      @(negedge clk);
      if (c < 22) begin
        chk($sformatf("t2_full_c%0d", c), 32'(pix_full), 32'(c >= 16));
        chk($sformatf("t2_ovf_c%0d", c),  32'(overflow), 32'(c >= 19));
        chk($sformatf("t2_req_c%0d", c),  32'(mem_req),  32'(c >= 3));
      end
    end
    tick(); mem_ack = 1'b1;
    wait_idle("t2", 200);
    chk("t2_ovf_sticky", 32'(overflow), 32'd1);

    // Reset clears the sticky flag
    tick(); areset = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst2");
    tick(); areset = 1'b0; sb.delete();

    // 3: out-of-bounds pixels are discarded without overflow
    bx = '{10'd640, 10'd0, 10'd0,   10'd1023};
    by = '{10'd0,   10'd3, 10'd480, 10'd1023};
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i < 4) drive_pix(int'(bx[i]), int'(by[i]), 4'hA);
      else       pix_we = 1'b0;
      @(negedge clk);
      chk($sformatf("t3_req_%0d", i),  32'(mem_req),  32'd0);
      chk($sformatf("t3_idle_%0d", i), 32'(idle),     32'd1);
      chk($sformatf("t3_ovf_%0d", i),  32'(overflow), 32'd0);
    end
    tick(); drive_pix(639, 2, 4'h7); push_exp(639, 2, 4'h7);
    tick(); pix_we = 1'b0;
    wait_idle("t3_corner", 20);

`ifdef FB_CLEAR_EN
    // 4: full clear sweep; a second start while busy is ignored
    tick(); clear_color = 4'h5; clear_start = 1'b1; push_clear(4'h5);
    @(negedge clk); chk("t4_busy_c0", 32'(clear_busy), 32'd0);
    tick(); clear_start = 1'b0;
    @(negedge clk); chk("t4_busy_c1", 32'(clear_busy), 32'd1);
    tick(); clear_start = 1'b1; clear_color = 4'h9;
    tick(); clear_start = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        chk("t4_busy_fall", 32'(clear_busy), 32'd0);
        break;
      end
      if (mem_req && mem_ack && mem_addr == ADDR_W'(LAST)) begin
        chk("t4_busy_at_last", 32'(clear_busy), 32'd1);
        done = 1'b1;
      end
    end
    chk("t4_last_seen", 32'(done), 32'd1);
    wait_idle("t4", 20);

    // 5: pixels buffered before a clear drain first; a mid-clear pixel follows the sweep
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); drive_pix(10 + i, 0, 4'(i + 1)); push_exp(10 + i, 0, 4'(i + 1));
    end
    tick(); pix_we = 1'b0;
    repeat (3) tick();
    clear_color = 4'hA; clear_start = 1'b1; push_clear(4'hA);
    tick(); clear_start = 1'b0;
    tick(); mem_ack = 1'b1;
    repeat (20) tick();
    drive_pix(5, 1, 4'hC); push_exp(5, 1, 4'hC);
    tick(); pix_we = 1'b0;
    wait_idle("t5", 4000);
`else
    // Without the clear feature, clear_start must have no effect
    tick(); clear_color = 4'h5; clear_start = 1'b1;
    tick(); clear_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("noclr_busy_%0d", i), 32'(clear_busy), 32'd0);
      chk($sformatf("noclr_req_%0d", i),  32'(mem_req),    32'd0);
      chk($sformatf("noclr_idle_%0d", i), 32'(idle),       32'd1);
    end
`endif

    // 6: stall during WRITE keeps outputs stable, then reset mid-activity
    mem_ack = 1'b0;
    tick(); drive_pix(1, 0, 4'h3); push_exp(1, 0, 4'h3);
    tick(); drive_pix(2, 0, 4'h4); push_exp(2, 0, 4'h4);
    tick(); pix_we = 1'b0;
    repeat (7) tick();
    mem_ack = 1'b1;
    wait_idle("t6_drain", 20);
`ifdef FB_CLEAR_EN
    tick(); clear_color = 4'h3; clear_start = 1'b1; push_clear(4'h3);
    tick(); clear_start = 1'b0;
    repeat (10) tick();
    chk("t6_busy_before_rst", 32'(clear_busy), 32'd1);
`else
    mem_ack = 1'b0;
    tick(); drive_pix(7, 1, 4'h6);
    tick(); pix_we = 1'b0;
    repeat (5) tick();
    chk("t6_req_before_rst", 32'(mem_req), 32'd1);
`endif
    areset = 1'b1;
    #1;
    check_reset_outputs("t6_rst");
    @(negedge clk);
    tick(); areset = 1'b0; sb.delete(); mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("t6_post_req_%0d", i),  32'(mem_req), 32'd0);
      chk($sformatf("t6_post_idle_%0d", i), 32'(idle),    32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
